cpu_boot_loader: RTL

//   Upstream boot stage for cpu: accepts a program image as a valid/ready word stream,

---
 rtl/cpu_boot_loader_if.sv | 32 +++
 rtl/cpu_boot_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/cpu_boot_loader_if.sv
// Bundle of the boot loader's host, image-stream, memory and CPU-control signals.
// The slave modport is the loader's view of the bundle. The master modport is the environment's view.
interface cpu_boot_loader_if #(
  parameter int W = 8,
  parameter int A = 5
) ();
  logic         start;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         mem_write;
  logic         mem_read;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data_out;
  logic [W-1:0] mem_data_in;
  logic         cpu_rst_n;
  logic         busy;
  logic         done;
  logic         error;

  modport slave (
    input  start, s_valid, s_data, mem_data_in,
    output s_ready, mem_write, mem_read, mem_addr, mem_data_out,
    output cpu_rst_n, busy, done, error
  );

  modport master (
    output start, s_valid, s_data, mem_data_in,
    input  s_ready, mem_write, mem_read, mem_addr, mem_data_out,
    input  cpu_rst_n, busy, done, error
  );
endinterface

// File: rtl/cpu_boot_loader.sv
// Streams a program image into CPU memory and can read it back to check a modular sum.
// CPU reset is released only after the image has been loaded, or loaded and verified.
module cpu_boot_loader #(
  parameter int DEFAULT_WORD_W = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int VERIFY_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  cpu_boot_loader_if.slave   bus
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_RD, S_CMP, S_RUN, S_FAIL
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DEFAULT_WORD_W-1:0] sum_wr_q, sum_wr_d;
  logic [DEFAULT_WORD_W-1:0] sum_rd_q, sum_rd_d;
  logic [DEFAULT_WORD_W-1:0] data_q, data_d;

  // Checksum addition wraps modulo 2**W; the carry is deliberately dropped.
  function automatic logic [DEFAULT_WORD_W-1:0] add_mod(
    input logic [DEFAULT_WORD_W-1:0] a,
    input logic [DEFAULT_WORD_W-1:0] b
  );
    return a + b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      sum_wr_q <= '0;
      sum_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sum_wr_q <= sum_wr_d;
      sum_rd_q <= sum_rd_d;
    end
  end

  // The word buffer is only observed in WRITE, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sum_wr_d = sum_wr_q;
    sum_rd_d = sum_rd_q;
    data_d   = data_q;
    unique case (state_q)
      S_IDLE, S_RUN, S_FAIL: begin
        if (bus.start) begin
          state_d  = S_LOAD;
          addr_d   = '0;
          sum_wr_d = '0;
          sum_rd_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.s_valid) begin
          data_d   = bus.s_data;
          sum_wr_d = add_mod(sum_wr_q, bus.s_data);
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = (VERIFY_EN != 0) ? S_RD : S_RUN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_RD: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        sum_rd_d = add_mod(sum_rd_q, bus.mem_data_in);
        if (addr_q == ADDR_LAST) begin
          addr_d  = '0;
          state_d = (sum_rd_d == sum_wr_q) ? S_RUN : S_FAIL;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory strobes, address and data stay zero outside WRITE/RD so the CPU owns memory in RUN.
  assign bus.s_ready      = (state_q == S_LOAD);
  assign bus.mem_write    = (state_q == S_WRITE);
  assign bus.mem_read     = (state_q == S_RD);
  assign bus.mem_addr     = ((state_q == S_WRITE) || (state_q == S_RD)) ? addr_q : '0;
  assign bus.mem_data_out = (state_q == S_WRITE) ? data_q : '0;
  assign bus.cpu_rst_n    = (state_q == S_RUN);
  assign bus.busy         = (state_q == S_LOAD) || (state_q == S_WRITE) ||
                            (state_q == S_RD)   || (state_q == S_CMP);
  assign bus.done         = (state_q == S_RUN);
  assign bus.error        = (state_q == S_FAIL);
endmodule
